// File: rtl/mux2_pkg.sv
// mux2_pkg: shared FSM state encoding and select constants for the mux2 stream arbiter
package mux2_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LOCK_A = 2'd1, LOCK_B = 2'd2} state_t;
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/mux2_bus.sv
// mux2_bus: combinational 2:1 steer of a {last,data} beat, sel=0 forwards a
module mux2_bus #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH:0]   b,
    output logic [WIDTH:0]   y
);
    assign y = sel ? b : a;
endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: packet-aware round-robin 2:1 stream arbiter with registered output
module mux2_rr_arbiter
    import mux2_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last,
    input  logic             y_ready,
    output logic             sel
);
    state_t         state_q, state_d;
    logic           prio_q, prio_d, sel_q, cand, out_free, xfer;
    logic [WIDTH:0] steer;

    assign out_free = !y_valid | y_ready;
    // with nothing valid the select parks on its previous value
    assign cand = (a_valid & b_valid) ? prio_q : a_valid ? SEL_A : b_valid ? SEL_B : sel_q;
    assign sel = rst ? SEL_A : (state_q == LOCK_A) ? SEL_A : (state_q == LOCK_B) ? SEL_B : cand;
    assign a_ready = !rst & out_free & (sel == SEL_A);
    assign b_ready = !rst & out_free & (sel == SEL_B);
    assign xfer = (sel == SEL_B) ? (b_valid & b_ready) : (a_valid & a_ready);

    mux2_bus #(.WIDTH(WIDTH)) u_bus (
        .sel (sel),
        .a   ({a_last, a_data}),
        .b   ({b_last, b_data}),
        .y   (steer)
    );

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        if (xfer) begin
            state_d = steer[WIDTH] ? IDLE : (sel == SEL_B) ? LOCK_B : LOCK_A;
            prio_d  = steer[WIDTH] ? !sel : prio_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= SEL_A;
            sel_q   <= SEL_A;
            y_valid <= 1'b0;
            y_data  <= '0;
            y_last  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            sel_q   <= sel;
            if (xfer) begin
                y_valid          <= 1'b1;
                {y_last, y_data} <= steer;
            end else if (y_ready) begin
                y_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed vector table plus hand sequences for lock, stall and reset cases
module tb_mux2_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst, a_valid, a_last, b_valid, b_last, y_ready;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, y_valid, y_last, sel;
    logic [7:0] y_data;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        logic       rst, av;
        logic [7:0] ad;
        logic       al, bv;
        logic [7:0] bd;
        logic       bl, yr;
        logic       e_ar, e_br, e_sel, e_yv;
        logic [7:0] e_yd;
        logic       e_yl;
    } vec_t;

    vec_t tbl[12];

    mux2_rr_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .y_ready(y_ready),
        .sel(sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [7:0] ad, input logic al,
                         input logic bv, input logic [7:0] bd, input logic bl, input logic yr);
        @(negedge clk);
        rst = r; a_valid = av; a_data = ad; a_last = al;
        b_valid = bv; b_data = bd; b_last = bl; y_ready = yr;
        #1;
    endtask

    initial begin
        tbl[0]  = '{1,1,8'h11,1,1,8'h22,1,1, 0,0,0,0,8'h00,0};
        tbl[1]  = '{1,1,8'h11,1,1,8'h22,1,1, 0,0,0,0,8'h00,0};
        tbl[2]  = '{0,1,8'h11,1,1,8'h22,1,1, 1,0,0,0,8'h00,0};
        tbl[3]  = '{0,1,8'h11,1,1,8'h22,1,1, 0,1,1,1,8'h11,1};
        tbl[4]  = '{0,1,8'h11,1,1,8'h22,1,1, 1,0,0,1,8'h22,1};
        tbl[5]  = '{0,1,8'h11,1,1,8'h22,1,1, 0,1,1,1,8'h11,1};
        tbl[6]  = '{0,1,8'hAA,0,1,8'h22,1,1, 1,0,0,1,8'h22,1};
        tbl[7]  = '{0,1,8'hAB,0,1,8'h22,1,1, 1,0,0,1,8'hAA,0};
        tbl[8]  = '{0,1,8'hAC,1,1,8'h22,1,1, 1,0,0,1,8'hAB,0};
        tbl[9]  = '{0,1,8'hAD,1,1,8'h33,1,1, 0,1,1,1,8'hAC,1};
        tbl[10] = '{0,0,8'h00,0,0,8'h00,0,1, 0,1,1,1,8'h33,1};
        tbl[11] = '{0,0,8'h00,0,0,8'h00,0,1, 0,1,1,0,8'h33,1};

        rst = 1; a_valid = 0; a_data = 0; a_last = 0;
        b_valid = 0; b_data = 0; b_last = 0; y_ready = 1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, tbl[i].av, tbl[i].ad, tbl[i].al,
                  tbl[i].bv, tbl[i].bd, tbl[i].bl, tbl[i].yr);
            chk($sformatf("v%0d a_ready", i), {7'd0, a_ready}, {7'd0, tbl[i].e_ar});
            chk($sformatf("v%0d b_ready", i), {7'd0, b_ready}, {7'd0, tbl[i].e_br});
            chk($sformatf("v%0d sel", i),     {7'd0, sel},     {7'd0, tbl[i].e_sel});
            chk($sformatf("v%0d y_valid", i), {7'd0, y_valid}, {7'd0, tbl[i].e_yv});
            chk($sformatf("v%0d y_data", i),  y_data,          tbl[i].e_yd);
            chk($sformatf("v%0d y_last", i),  {7'd0, y_last},  {7'd0, tbl[i].e_yl});
        end

        // backpressure: 5A is registered, then held for 4 stalled cycles
        drive(0, 1, 8'h5A, 1, 0, 8'h00, 0, 0);
        chk("bp load a_ready", {7'd0, a_ready}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 8'h5B, 1, 1, 8'h66, 1, 0);
            chk($sformatf("bp%0d y_data", i), y_data, 8'h5A);
            chk($sformatf("bp%0d y_valid", i), {7'd0, y_valid}, 8'd1);
            chk($sformatf("bp%0d readies", i), {6'd0, a_ready, b_ready}, 8'd0);
        end
        drive(0, 1, 8'h5B, 1, 1, 8'h66, 1, 1);
        chk("bp release b_ready", {7'd0, b_ready}, 8'd1);
        chk("bp release y_data", y_data, 8'h5A);
        drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        chk("bp next y_data", y_data, 8'h66);

        // stall inside a B lock: A must stay starved
        drive(0, 0, 8'h00, 0, 1, 8'hB0, 0, 1);
        chk("lock start b_ready", {7'd0, b_ready}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 8'hA5, 1, 0, 8'h00, 0, 1);
            chk($sformatf("stall%0d a_ready", i), {7'd0, a_ready}, 8'd0);
            chk($sformatf("stall%0d sel", i), {7'd0, sel}, 8'd1);
        end
        chk("stall y_valid", {7'd0, y_valid}, 8'd0);
        drive(0, 1, 8'hA5, 1, 1, 8'hB1, 1, 1);
        chk("resume b_ready", {7'd0, b_ready}, 8'd1);
        chk("resume a_ready", {7'd0, a_ready}, 8'd0);
        drive(0, 1, 8'hA5, 1, 1, 8'hB2, 1, 1);
        chk("after lock a_ready", {7'd0, a_ready}, 8'd1);
        chk("after lock sel", {7'd0, sel}, 8'd0);
        chk("after lock y_data", y_data, 8'hB1);
        chk("after lock y_last", {7'd0, y_last}, 8'd1);

        // reset after the second beat of a 4-beat B packet
        drive(0, 0, 8'h00, 0, 1, 8'hC1, 0, 1);
        chk("pkt c1 b_ready", {7'd0, b_ready}, 8'd1);
        drive(0, 0, 8'h00, 0, 1, 8'hC2, 0, 1);
        chk("pkt c2 b_ready", {7'd0, b_ready}, 8'd1);
        drive(1, 0, 8'h00, 0, 1, 8'hC3, 0, 1);
        chk("rst readies", {6'd0, a_ready, b_ready}, 8'd0);
        drive(0, 1, 8'hD1, 1, 0, 8'h00, 0, 1);
        chk("post rst y_valid", {7'd0, y_valid}, 8'd0);
        chk("post rst a_ready", {7'd0, a_ready}, 8'd1);
        chk("post rst sel", {7'd0, sel}, 8'd0);
        drive(0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        chk("post rst y_data", y_data, 8'hD1);
        chk("post rst y_valid2", {7'd0, y_valid}, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
